// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_pkg
// Brief    : Shared types and sizing helpers for the bit-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int w);
      return ($clog2(w) < 1) ? 1 : $clog2(w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
`default_nettype none
// ============================================================================
// Module   : fa_cell
// Brief    : Combinational one-bit full adder; drop-in slot for a gate netlist.
// Revision : 1.0 - initial release
// ============================================================================
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : WIDTH-bit adder evaluated LSB-first through one full-adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int c_cnt_w = cnt_width(WIDTH);

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-1:0]   r_sum_sh;
   logic [WIDTH-1:0]   w_sum_next;
   logic [c_cnt_w-1:0] r_count;
   logic               r_carry;
   logic               r_out_valid;
   logic               w_s;
   logic               w_co;
   logic               w_last;
   logic               w_drain;

   fa_cell u_fa (
      .a  (r_a_sh[0]),
      .b  (r_b_sh[0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   assign w_last  = (r_count == c_cnt_w'(WIDTH - 1));
   // The result is only released once out_valid has actually been presented.
   assign w_drain = (r_state == DONE) && r_out_valid && out_ready;

   generate
      if (WIDTH == 1) begin : g_sum_w1
         assign w_sum_next = w_s;
      end else begin : g_sum_wn
         assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_next = RUN;
         RUN:     if (w_last)   w_state_next = DONE;
         DONE:    if (w_drain)  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = r_out_valid;
      sum       = r_sum_sh;
      cout      = r_carry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh      <= '0;
         r_b_sh      <= '0;
         r_sum_sh    <= '0;
         r_count     <= '0;
         r_carry     <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= (r_state == DONE) && !w_drain;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a_sh  <= a;
                  r_b_sh  <= b;
                  r_carry <= cin;
                  r_count <= '0;
               end
            end
            RUN: begin
               r_carry  <= w_co;
               r_sum_sh <= w_sum_next;
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               if (!w_last) begin
                  r_count <= r_count + c_cnt_w'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Directed and random checks of serial_adder at WIDTH 1, 8 and 13.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] a;
   logic [63:0] b;
   logic        cin;
   logic [2:0]  iv;
   logic [2:0]  ordy;
   logic [2:0]  rdy;
   logic [2:0]  ov;
   logic [2:0]  cv;
   logic [0:0]  s1;
   logic [7:0]  s8;
   logic [12:0] s13;
   logic [63:0] sv [3];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign sv[0] = 64'(s1);
   assign sv[1] = 64'(s8);
   assign sv[2] = 64'(s13);

   serial_adder #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
      .a(a[0:0]), .b(b[0:0]), .cin(cin), .out_valid(ov[0]),
      .out_ready(ordy[0]), .sum(s1), .cout(cv[0])
   );

   serial_adder #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(ov[1]),
      .out_ready(ordy[1]), .sum(s8), .cout(cv[1])
   );

   serial_adder #(.WIDTH(13)) u_w13 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]),
      .a(a[12:0]), .b(b[12:0]), .cin(cin), .out_valid(ov[2]),
      .out_ready(ordy[2]), .sum(s13), .cout(cv[2])
   );

   function automatic int width_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 8 : 13;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One full transaction on DUT k; optional operand noise during RUN and a
   // backpressure hold of 'hold' cycles in DONE before the result is taken.
   task automatic run_op(input int k, input logic [63:0] av, input logic [63:0] bv,
                         input logic c, input bit noise, input int hold,
                         output logic [63:0] s, output logic co, output int lat);
      int  n;
      bit  ok;
      @(negedge clk);
      a = av; b = bv; cin = c; iv[k] = 1'b1;
      n = 0;
      while (!rdy[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("ready_wait", 64'(rdy[k]), 64'd1);
      @(posedge clk); #1;
      iv[k] = 1'b0;
      lat = 0;
      ok  = 1'b1;
      while (!ov[k] && lat < 200) begin
         if (noise) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            cin = 1'($urandom); iv[k] = 1'b1;
            if (rdy[k] !== 1'b0) ok = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      iv[k] = 1'b0;
      if (lat >= 200) check("valid_timeout", 64'(ov[k]), 64'd1);
      if (noise) check("busy_no_ready", 64'(ok), 64'd1);
      s  = sv[k];
      co = cv[k];
      if (hold > 0) begin
         ok = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (ov[k] !== 1'b1 || sv[k] !== s || cv[k] !== co || rdy[k] !== 1'b0) ok = 1'b0;
         end
         check("hold_stable", 64'(ok), 64'd1);
      end
      ordy[k] = 1'b1;
      @(posedge clk); #1;
      ordy[k] = 1'b0;
      if (hold > 0) begin
         check("drain_valid_low", 64'(ov[k]), 64'd0);
         check("drain_idle_ready", 64'(rdy[k]), 64'd1);
      end
   endtask

   logic [63:0] s;
   logic        co;
   int          lat;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] av, bv, m;
      logic [64:0] full;
      logic        c;
      int          w;

      rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; iv = '0; ordy = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(rdy[1]), 64'd1);
      check("rst_out_valid", 64'(ov[1]), 64'd0);
      check("rst_sum", sv[1], 64'd0);
      check("rst_cout", 64'(cv[1]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(1, 64'h5A, 64'h33, 1'b0, 1'b0, 0, s, co, lat);
      check("5a_33_sum", s, 64'h8D);
      check("5a_33_cout", 64'(co), 64'd0);
      check("5a_33_latency", 64'(lat), 64'd9);

      run_op(1, 64'hFF, 64'h01, 1'b0, 1'b0, 0, s, co, lat);
      check("ff_01_sum", s, 64'h00);
      check("ff_01_cout", 64'(co), 64'd1);

      run_op(1, 64'hFF, 64'hFF, 1'b1, 1'b0, 0, s, co, lat);
      check("ff_ff_c1_sum", s, 64'hFF);
      check("ff_ff_c1_cout", 64'(co), 64'd1);

      run_op(1, 64'h12, 64'h34, 1'b1, 1'b1, 0, s, co, lat);
      check("noise_sum", s, 64'h47);
      check("noise_cout", 64'(co), 64'd0);

      run_op(1, 64'hA5, 64'h5A, 1'b0, 1'b0, 5, s, co, lat);
      check("bp_sum", s, 64'hFF);
      check("bp_cout", 64'(co), 64'd0);

      // Abort mid-RUN: count has reached 3 when reset hits.
      @(negedge clk);
      a = 64'hF0; b = 64'h0F; cin = 1'b1; iv[1] = 1'b1;
      @(posedge clk); #1;
      iv[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", 64'(rdy[1]), 64'd1);
      check("abort_out_valid", 64'(ov[1]), 64'd0);
      check("abort_sum", sv[1], 64'd0);
      check("abort_cout", 64'(cv[1]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1, 64'h01, 64'h02, 1'b0, 1'b0, 0, s, co, lat);
      check("post_rst_sum", s, 64'h03);
      check("post_rst_cout", 64'(co), 64'd0);

      run_op(0, 64'h1, 64'h1, 1'b1, 1'b0, 0, s, co, lat);
      check("w1_sum", s, 64'h1);
      check("w1_cout", 64'(co), 64'd1);
      check("w1_latency", 64'(lat), 64'd2);

      run_op(2, 64'h1FFF, 64'h0001, 1'b0, 1'b0, 0, s, co, lat);
      check("w13_sum", s, 64'h0000);
      check("w13_cout", 64'(co), 64'd1);
      check("w13_latency", 64'(lat), 64'd14);

      for (int k = 0; k < 3; k++) begin
         w = width_of(k);
         m = (64'd1 << w) - 64'd1;
         for (int i = 0; i < 4; i++) begin
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            c  = 1'($urandom);
            full = {1'b0, av & m} + {1'b0, bv & m} + 65'(c);
            run_op(k, av, bv, c, 1'b0, 0, s, co, lat);
            check("rand_sum", s, full[63:0] & m);
            check("rand_cout", 64'(co), 64'(full[w]));
            check("rand_latency", 64'(lat), 64'(w + 1));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
